// File: rtl/booth_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mac_pkg
//  Purpose  : Shared types and helpers for the sequential radix-4 Booth MAC.
//             Holds the FSM state encoding, the decoded Booth digit and the
//             digit-count function.
//  Revision : 1.0 - initial release
// ============================================================================
package booth_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Decoded radix-4 digit: value = (neg ? -1 : 1) * (zero ? 0 : (two ? 2 : 1))
    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // Number of radix-4 digits needed to cover a multiplier of b_w bits plus
    // one guard bit, so unsigned operands recode correctly as well.
    function automatic int booth_digits(input int b_w);
        return (b_w + 2) / 2;
    endfunction

    function automatic booth_digit_t booth_encode(input logic [2:0] win);
        booth_digit_t d;
        d.neg  = win[2];
        d.two  = (win == 3'b011) || (win == 3'b100);
        d.zero = (win == 3'b000) || (win == 3'b111);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_digit_pp.sv
`default_nettype none
// ============================================================================
//  Module   : booth_digit_pp
//  Purpose  : Combinational radix-4 Booth encoder/decoder. Turns one 3-bit
//             multiplier window into a partial product of the extended
//             multiplicand, modulo 2^OUT_W.
//  Ports    : i_win   - multiplier window {b[2k+1], b[2k], b[2k-1]}
//             i_a_ext - extended (and pre-shifted) multiplicand
//             o_pp    - partial product, digit * i_a_ext
//  Revision : 1.0 - initial release
// ============================================================================
module booth_digit_pp
    import booth_mac_pkg::*;
#(
    parameter int OUT_W = 24
) (
    input  logic [2:0]       i_win,
    input  logic [OUT_W-1:0] i_a_ext,
    output logic [OUT_W-1:0] o_pp
);

    booth_digit_t     w_dig;
    logic [OUT_W-1:0] w_mag;

    always_comb begin
        w_dig = booth_encode(i_win);
        if (w_dig.zero) begin
            w_mag = '0;
        end else if (w_dig.two) begin
            w_mag = i_a_ext << 1;
        end else begin
            w_mag = i_a_ext;
        end
        o_pp = w_dig.neg ? (~w_mag + 1'b1) : w_mag;
    end

endmodule
`default_nettype wire

// File: rtl/booth_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mac_seq
//  Purpose  : Iterative radix-4 Booth multiply-accumulate,
//             out_res = a*b + addend (mod 2^OUT_W), one digit per cycle.
//             The addend is in_c or the internal accumulator (in_acc=1).
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             in_valid/in_ready         - operation handshake
//             in_a, in_b, in_c          - multiplicand, multiplier, addend
//             in_sgn                    - 1: two's complement, 0: unsigned
//             in_acc                    - 1: use accumulator as addend
//             out_valid/out_ready       - result handshake
//             out_res                   - result
//  Revision : 1.0 - initial release
// ============================================================================
module booth_mac_seq
    import booth_mac_pkg::*;
#(
    parameter int A_W   = 12,
    parameter int B_W   = 12,
    parameter int C_W   = 23,
    parameter int OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic [C_W-1:0]   in_c,
    input  logic             in_sgn,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_res
);

    localparam int C_DIGITS  = booth_digits(B_W);
    localparam int C_B_EXT_W = 2 * C_DIGITS;
    localparam int C_CNT_W   = $clog2(C_DIGITS + 1);

    state_t               r_state;
    logic [OUT_W-1:0]     r_a;
    logic [C_B_EXT_W:0]   r_b;      // extended b with the implicit bit -1 at [0]
    logic [OUT_W-1:0]     r_sum;
    logic [OUT_W-1:0]     r_acc;
    logic [C_CNT_W-1:0]   r_cnt;

    logic [OUT_W-1:0]     w_a_ext;
    logic [OUT_W-1:0]     w_c_ext;
    logic [C_B_EXT_W-1:0] w_b_ext;
    logic [OUT_W-1:0]     w_pp;

    // Operand extension; the fill bit is the sign bit only in signed mode.
    generate
        if (OUT_W > A_W) begin : g_a_ext
            assign w_a_ext = {{(OUT_W-A_W){in_sgn & in_a[A_W-1]}}, in_a};
        end else begin : g_a_full
            assign w_a_ext = in_a;
        end
        if (OUT_W > C_W) begin : g_c_ext
            assign w_c_ext = {{(OUT_W-C_W){in_sgn & in_c[C_W-1]}}, in_c};
        end else begin : g_c_full
            assign w_c_ext = in_c;
        end
    endgenerate

    assign w_b_ext = {{(C_B_EXT_W-B_W){in_sgn & in_b[B_W-1]}}, in_b};

    // r_a is pre-shifted by 2k and r_b shifted down by 2k, so the shared
    // generator always sees the current digit's window at r_b[2:0].
    booth_digit_pp #(
        .OUT_W (OUT_W)
    ) u_pp (
        .i_win   (r_b[2:0]),
        .i_a_ext (r_a),
        .o_pp    (w_pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_a_ext;
                        r_b     <= {w_b_ext, 1'b0};
                        r_sum   <= in_acc ? r_acc : w_c_ext;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum <= r_sum + w_pp;
                    r_a   <= r_a << 2;
                    r_b   <= r_b >> 2;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_W'(C_DIGITS - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_acc   <= r_sum;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_res   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_mac_seq
//  Purpose  : Directed self-checking bench for booth_mac_seq at default
//             parameters, with hand-computed expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mac_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic [22:0] in_c;
    logic        in_sgn;
    logic        in_acc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_res;

    int n_checks = 0;
    int n_errors = 0;

    booth_mac_seq #(
        .A_W   (12),
        .B_W   (12),
        .C_W   (23),
        .OUT_W (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_sgn    (in_sgn),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from IDLE, wait (bounded) for the result, then take it.
    task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                          input logic [22:0] c, input logic sgn, input logic acc,
                          output logic [23:0] res, output int lat,
                          output logic rdy_after);
        in_a = a; in_b = b; in_c = c; in_sgn = sgn; in_acc = acc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_res;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_sgn = 1'b0; in_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_checks++;
        if (out_res !== 24'h0) begin
            n_errors++; $display("FAIL reset_out_res got=%h exp=000000", out_res);
        end
    endtask

    task automatic test_signed_min();
        logic [23:0] res; int lat; logic rdy;
        run_op(12'h800, 12'h800, 23'h0, 1'b1, 1'b0, res, lat, rdy);
        n_checks++;
        if (lat !== 7) begin
            n_errors++; $display("FAIL signed_min_latency got=%0d exp=7", lat);
        end
        n_checks++;
        if (res !== 24'h400000) begin
            n_errors++; $display("FAIL signed_min_res got=%h exp=400000", res);
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_errors++; $display("FAIL signed_min_ready_after got=%b exp=1", rdy);
        end
    endtask

    task automatic test_unsigned_vs_signed();
        logic [23:0] res; int lat; logic rdy;
        run_op(12'hFFF, 12'hFFF, 23'h0, 1'b0, 1'b0, res, lat, rdy);
        n_checks++;
        if (res !== 24'hFFE001) begin
            n_errors++; $display("FAIL unsigned_max_res got=%h exp=ffe001", res);
        end
        n_checks++;
        if (lat !== 7) begin
            n_errors++; $display("FAIL unsigned_latency got=%0d exp=7", lat);
        end
        run_op(12'hFFF, 12'hFFF, 23'h0, 1'b1, 1'b0, res, lat, rdy);
        n_checks++;
        if (res !== 24'h000001) begin
            n_errors++; $display("FAIL signed_m1_res got=%h exp=000001", res);
        end
    endtask

    task automatic test_neg_addend();
        logic [23:0] res; int lat; logic rdy;
        run_op(12'd1234, 12'(-567), 23'(-100000), 1'b1, 1'b0, res, lat, rdy);
        n_checks++;
        if (res !== 24'hF3CC42) begin
            n_errors++; $display("FAIL neg_addend_res got=%h exp=f3cc42", res);
        end
    endtask

    task automatic test_accumulate();
        logic [23:0] res; int lat; logic rdy;
        run_op(12'd3, 12'd4, 23'd10, 1'b1, 1'b0, res, lat, rdy);
        n_checks++;
        if (res !== 24'd22) begin
            n_errors++; $display("FAIL acc_first got=%0d exp=22", res);
        end
        // in_c carries junk to prove it is ignored when accumulating
        run_op(12'd5, 12'd6, 23'h5A5A5, 1'b1, 1'b1, res, lat, rdy);
        n_checks++;
        if (res !== 24'd52) begin
            n_errors++; $display("FAIL acc_second got=%0d exp=52", res);
        end
        run_op(12'hFFF, 12'd52, 23'h1234, 1'b1, 1'b1, res, lat, rdy);
        n_checks++;
        if (res !== 24'd0) begin
            n_errors++; $display("FAIL acc_third got=%0d exp=0", res);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] res; int lat; logic rdy;
        // 100 * -3 + 7 = -293
        in_a = 12'd100; in_b = 12'(-3); in_c = 23'd7; in_sgn = 1'b1; in_acc = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 7) begin
            n_errors++; $display("FAIL bp_latency got=%0d exp=7", lat);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_a = 12'($urandom); in_b = 12'($urandom);
            in_c = 23'($urandom); in_acc = ~i[0]; in_sgn = i[1];
            n_checks++;
            if (out_res !== 24'hFFFEDB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold[%0d] got res=%h valid=%b ready=%b exp res=fffedb valid=1 ready=0",
                         i, out_res, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
        // accumulator must now hold -293: -293 + 1*1 = -292
        run_op(12'd1, 12'd1, 23'h0, 1'b1, 1'b1, res, lat, rdy);
        n_checks++;
        if (res !== 24'hFFFEDC) begin
            n_errors++; $display("FAIL bp_acc_after got=%h exp=fffedc", res);
        end
    endtask

    task automatic test_reset_abort();
        logic [23:0] res; int lat; logic rdy;
        in_a = 12'd77; in_b = 12'd99; in_c = 23'd5; in_sgn = 1'b0; in_acc = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_state got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
        // accumulator held -292 before reset; it must be cleared
        run_op(12'd2, 12'd2, 23'h7FFFFF, 1'b1, 1'b1, res, lat, rdy);
        n_checks++;
        if (res !== 24'd4) begin
            n_errors++; $display("FAIL abort_acc_cleared got=%h exp=000004", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] res; int lat; logic rdy;
        run_op(12'd0, 12'd0, 23'h0, 1'b0, 1'b1, res, lat, rdy);
        n_checks++;
        if (res !== 24'd4) begin
            n_errors++; $display("FAIL b2b_first got=%h exp=000004", res);
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_errors++; $display("FAIL b2b_ready got=%b exp=1", rdy);
        end
        // unsigned 2048*2048 = 0x400000 plus accumulated 4
        run_op(12'h800, 12'h800, 23'h0, 1'b0, 1'b1, res, lat, rdy);
        n_checks++;
        if (res !== 24'h400004) begin
            n_errors++; $display("FAIL b2b_second got=%h exp=400004", res);
        end
    endtask

    initial begin
        test_reset();
        test_signed_min();
        test_unsigned_vs_signed();
        test_neg_addend();
        test_accumulate();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_mac_seq.md
# booth_mac_seq

Sequential, parametrised radix-4 Booth multiply-accumulate unit computing `res = a*b + addend` modulo 2^OUT_W. It is the iterative successor to our combinational 12-bit Booth arrays: one Booth digit per cycle through a single shared partial-product generator. It adds runtime signed/unsigned selection, an internal running accumulator, and valid/ready handshakes on both sides. It sits between operand sequencing and result consumers in the datapath.

## Interface
- `A_W`, 12, multiplicand width
- `B_W`, 12, multiplier width (Booth-recoded operand)
- `C_W`, 23, external addend width
- `OUT_W`, 24, result and accumulator width; must be ≥ max(A_W+B_W, C_W)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `in_valid` input 1 — operation request
- `in_ready` output 1 — unit can accept an operation
- `in_a` input A_W — multiplicand
- `in_b` input B_W — multiplier
- `in_c` input C_W — addend, used when `in_acc`=0
- `in_sgn` input 1 — 1: a, b, c are two's complement; 0: unsigned
- `in_acc` input 1 — 1: addend is the internal accumulator and `in_c` is ignored
- `out_valid` output 1 — result available
- `out_ready` input 1 — consumer takes the result
- `out_res` output OUT_W — result

## Operation
- Digit count D = ceil((B_W+1)/2); D=7 at defaults. The same D applies in both modes.
- Operand extension: a and c are sign-extended when `in_sgn`=1 and zero-extended when 0, up to OUT_W. b is extended the same way to 2D bits.
- Booth digit k uses b bits {2k+1, 2k, 2k−1}, with bit −1 = 0. Digit value ∈ {−2,−1,0,+1,+2}.
- States:
  - IDLE: `in_ready`=1. On `in_valid`: capture the operands and mode; load the working sum with the extended c, or with the accumulator when `in_acc`=1; clear the digit counter; go to RUN.
  - RUN: each cycle, working sum += (digit_k · a_ext) << 2k, truncated to OUT_W. After digit D−1, go to DONE.
  - DONE: `out_valid`=1 and `out_res` = working sum. On `out_ready`: write the result into the accumulator and go to IDLE.
- All arithmetic wraps modulo 2^OUT_W. No saturation, no overflow flag.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Inputs are ignored outside IDLE. `in_valid` is not required to stay asserted after acceptance.
- The accumulator updates only on a completed output handshake. A result that is never accepted never reaches the accumulator.

## Timing
- Reset values (applied at the clock edge while `rst`=1):
  - state IDLE
  - `in_ready`=1 from the first cycle after reset
  - `out_valid`=0
  - `out_res`=0
  - accumulator=0
  - digit counter=0
- Reset in RUN or DONE aborts the operation. No result is produced and the accumulator is cleared.
- Accept edge t0. RUN covers edges t1..tD. `out_valid` is high in the cycle following edge tD, i.e. D cycles after the accept edge.
- `out_valid` and `out_res` stay stable until the `out_ready` handshake. `in_ready` returns the cycle after the handshake.
- Maximum throughput is one operation per D+2 cycles.
- `in_acc`=1 on the first operation after reset uses addend 0.

## Structure
- `booth_mac_pkg` holds:
  - the state enum (IDLE, RUN, DONE)
  - the Booth digit typedef (neg, two, zero flags)
  - a constant function computing D from B_W
- Sub-module `booth_digit_pp`: combinational radix-4 encoder and decoder.
  - Inputs: the 3-bit window and the extended a.
  - Outputs: the OUT_W-wide signed partial product.
  - One instance is shared across all iterations.
- The top level holds the FSM, digit counter, shift/select of b windows, working sum, and accumulator.

## Test plan
All scenarios use the defaults (A_W=B_W=12, OUT_W=24).
- Signed: a=−2048, b=−2048, c=0 → `out_res`=0x400000. `out_valid` rises exactly 7 cycles after the accept edge.
- Unsigned: a=4095, b=4095, c=0 → 0xFFE001. The same operands in signed mode give 1.
- Signed with negative addend: a=1234, b=−567, c=−100000 → −799678 (0xF3CC42).
- Accumulate chain:
  - First op: `in_acc`=0, a=3, b=4, c=10 → 22.
  - Second op: `in_acc`=1, a=5, b=6 → 52.
  - Third op: `in_acc`=1, a=−1, b=52 → 0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and the inputs → `out_res` stable, `in_ready`=0, accumulator unchanged. The result is taken on the first `out_ready`.
- Reset at RUN cycle 3 → next cycle `out_valid`=0 and `in_ready`=1. A following op with `in_acc`=1, a=2, b=2 → 4.
